// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle for one slave select: master drives address/control/write data,
// slave returns read data and its ready/response.
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte-lane writable word memory with programmable wait states
// on OKAY transfers and a two-cycle ERROR response for out-of-range/illegal accesses.
module ahb_sram_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int         NBYTES    = DATA_W / 8;
  localparam int         LANE_W    = $clog2(NBYTES);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         OFF_W     = IDX_W + LANE_W;
  localparam logic [2:0] MAX_SIZE  = 3'(LANE_W);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_wait_cnt;
  logic [OFF_W-1:0]    r_addr;
  logic                r_write;
  logic [2:0]          r_size;
  logic                r_err;

  logic                w_addr_phase;
  logic                w_take;
  logic [7:0]          w_align_mask;
  logic                w_misalign;
  logic                w_oob;
  logic                w_err;
  logic [NBYTES-1:0]   w_size_ones;
  logic [NBYTES-1:0]   w_be;
  logic [IDX_W-1:0]    w_idx;
  logic                w_we;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_ready;
  logic                w_resp;
  logic [DATA_W-1:0]   w_hrdata;
  logic                w_unused;

  // The bus can only hand us a new address phase in cycles where we drive HREADYOUT high.
  assign w_addr_phase = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_take       = w_addr_phase && bus.HSEL && bus.HREADY && bus.HTRANS[1];

  assign w_align_mask = (8'd1 << bus.HSIZE) - 8'd1;
  assign w_misalign   = |(bus.HADDR[7:0] & w_align_mask);
  assign w_oob        = |bus.HADDR[ADDR_W-1:OFF_W];
  assign w_err        = w_oob || (bus.HSIZE > MAX_SIZE) || w_misalign;
  assign w_unused     = bus.HTRANS[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_err   <= 1'b0;
    end else if (w_take) begin
      r_addr  <= bus.HADDR[OFF_W-1:0];
      r_write <= bus.HWRITE;
      r_size  <= bus.HSIZE;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wait_cnt <= 4'd0;
    end else if (w_take && !w_err) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b1;
    w_resp       = 1'b0;
    w_hrdata     = '0;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (r_state == ST_ERR2) begin
          w_resp = 1'b1;
        end
        if ((r_state == ST_DATA) && !r_write) begin
          w_hrdata = w_rdata;
        end
        if (w_take) begin
          if (w_err) begin
            w_state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_next = ST_WAIT;
          end else begin
            w_state_next = ST_DATA;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_ready = 1'b0;
        if (r_wait_cnt == 4'd0) begin
          w_state_next = ST_DATA;
        end
      end
      ST_ERR1: begin
        w_ready      = 1'b0;
        w_resp       = 1'b1;
        w_state_next = ST_ERR2;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.HREADYOUT = w_ready;
  assign bus.HRESP     = w_resp;
  assign bus.HRDATA    = w_hrdata;

  // Aligned accesses never spill past the top lane, so a plain shift gives the lane mask.
  assign w_be  = w_size_ones << r_addr[LANE_W-1:0];
  assign w_idx = r_addr[OFF_W-1:LANE_W];
  assign w_we  = (r_state == ST_DATA) && r_write && !r_err;

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      assign w_size_ones[gi] = (32'(gi) < (32'd1 << r_size));

      always_ff @(posedge HCLK) begin
        if (w_we && w_be[gi]) begin
          r_mem[w_idx] <= bus.HWDATA[8*gi +: 8];
        end
      end

      assign w_rdata[8*gi +: 8] = r_mem[w_idx];
    end
  endgenerate

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Drives two slaves (zero and three wait states) through a pipelined AHB master model and
// checks every data phase against a byte-array memory model.
module tb_ahb_sram_slave;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        t_hsel;
  logic [31:0] t_haddr;
  logic [1:0]  t_htrans;
  logic        t_hwrite;
  logic [2:0]  t_hsize;
  logic [31:0] t_hwdata;
  logic        w_rdy;
  logic        w_resp;
  logic [31:0] w_rdata;

  always #5 clk = ~clk;

  ahb_sram_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  ahb_sram_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  ahb_sram_slave #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus0)
  );
  ahb_sram_slave #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus3)
  );

  assign bus0.HSEL   = t_hsel & ~sel;
  assign bus3.HSEL   = t_hsel & sel;
  assign bus0.HADDR  = t_haddr;
  assign bus3.HADDR  = t_haddr;
  assign bus0.HTRANS = t_htrans;
  assign bus3.HTRANS = t_htrans;
  assign bus0.HWRITE = t_hwrite;
  assign bus3.HWRITE = t_hwrite;
  assign bus0.HSIZE  = t_hsize;
  assign bus3.HSIZE  = t_hsize;
  assign bus0.HWDATA = t_hwdata;
  assign bus3.HWDATA = t_hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  assign w_rdy   = sel ? bus3.HREADYOUT : bus0.HREADYOUT;
  assign w_resp  = sel ? bus3.HRESP     : bus0.HRESP;
  assign w_rdata = sel ? bus3.HRDATA    : bus0.HRDATA;

  typedef struct {
    logic [31:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
  } xfer_t;

  xfer_t      q[$];
  logic [7:0] mdl [2][MEM_BYTES];
  int         n_cmp = 0;
  int         n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] s);
    return (a >= 32'(MEM_BYTES)) || (s > 3'd2) || ((a % (32'd1 << s)) != 32'd0);
  endfunction

  function automatic logic [31:0] mdl_word(input int s, input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mdl[s][b+3], mdl[s][b+2], mdl[s][b+1], mdl[s][b]};
  endfunction

  task automatic mdl_write(input int s, input xfer_t x);
    int lane;
    int a;
    lane = int'(x.addr) % 4;
    a    = int'(x.addr);
    for (int k = 0; k < (1 << x.size); k++) begin
      mdl[s][a+k] = x.wdata[8*(lane+k) +: 8];
    end
  endtask

  task automatic push(input logic [31:0] a, input bit w, input logic [2:0] s, input logic [31:0] d);
    xfer_t x;
    x.addr  = a;
    x.write = w;
    x.size  = s;
    x.wdata = d;
    x.err   = exp_err(a, s);
    q.push_back(x);
  endtask

  task automatic push_random();
    int          r;
    logic [2:0]  s;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    s = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
    a = 32'($urandom_range(0, MEM_BYTES - 1));
    if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
    if ($urandom_range(0, 19) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
    if ($urandom_range(0, 39) == 0) a = $urandom;
    push(a, 1'($urandom_range(0, 1)), s, $urandom);
  endtask

  // One address phase per ready cycle; bus lines are scrambled while the slave stalls.
  task automatic run_q(input bit gaps);
    xfer_t d;
    bit    have_d = 1'b0;
    bit    stalled;
    int    stall = 0;
    int    s = int'(sel);
    int    ws = sel ? 3 : 0;
    while (have_d || q.size() > 0) begin
      @(negedge clk);
      stalled = 1'b0;
      if (have_d) begin
        if (!w_rdy) begin
          stall++;
          chk("stall_hresp", 64'(w_resp), 64'(d.err));
          chk("stall_hrdata", 64'(w_rdata), 64'd0);
          if (stall > 20) begin
            chk("stall_bound", 64'(stall), 64'(d.err ? 1 : ws));
            have_d = 1'b0;
          end else begin
            stalled  = 1'b1;
            t_hsel   = 1'($urandom_range(0, 1));
            t_htrans = 2'($urandom);
            t_haddr  = $urandom;
            t_hwrite = 1'($urandom);
            t_hsize  = 3'($urandom);
            t_hwdata = $urandom;
          end
        end else begin
          t_hwdata = d.wdata;
          chk("hresp", 64'(w_resp), 64'(d.err));
          chk("stall_cycles", 64'(stall), 64'(d.err ? 1 : ws));
          chk("hrdata", 64'(w_rdata), 64'((d.write || d.err) ? 32'd0 : mdl_word(s, d.addr)));
          if (d.write && !d.err) mdl_write(s, d);
          have_d = 1'b0;
        end
      end else begin
        chk("idle_hreadyout", 64'(w_rdy), 64'd1);
        chk("idle_hresp", 64'(w_resp), 64'd0);
      end
      if (!stalled) begin
        if ((q.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0))) begin
          d        = q.pop_front();
          have_d   = 1'b1;
          stall    = 0;
          t_hsel   = 1'b1;
          t_htrans = (gaps && ($urandom_range(0, 1) == 1)) ? 2'd3 : 2'd2;
          t_haddr  = d.addr;
          t_hwrite = d.write;
          t_hsize  = d.size;
        end else begin
          t_hsel   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          t_htrans = gaps ? 2'($urandom_range(0, 1)) : 2'd0;
          t_haddr  = $urandom;
          t_hwrite = 1'($urandom);
          t_hsize  = 3'($urandom);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel      = 1'b0;
    rst_n    = 1'b0;
    t_hsel   = 1'b0;
    t_haddr  = 32'd0;
    t_htrans = 2'd0;
    t_hwrite = 1'b0;
    t_hsize  = 3'd0;
    t_hwdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_hreadyout0", 64'(bus0.HREADYOUT), 64'd1);
    chk("rst_hresp0", 64'(bus0.HRESP), 64'd0);
    chk("rst_hrdata0", 64'(bus0.HRDATA), 64'd0);
    chk("rst_hreadyout3", 64'(bus3.HREADYOUT), 64'd1);
    chk("rst_hresp3", 64'(bus3.HRESP), 64'd0);
    chk("rst_hrdata3", 64'(bus3.HRDATA), 64'd0);
    rst_n = 1'b1;

    t_hsel   = 1'b1;
    t_htrans = 2'd0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_sel_hreadyout", 64'(w_rdy), 64'd1);
      chk("idle_sel_hresp", 64'(w_resp), 64'd0);
    end

    for (int i = 0; i < 256; i++) push(32'(i * 4), 1'b1, 3'd2, $urandom);
    run_q(1'b1);

    push(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    push(32'h10, 1'b0, 3'd2, 32'd0);
    run_q(1'b0);

    push(32'h20, 1'b1, 3'd2, 32'h11223344);
    push(32'h21, 1'b1, 3'd0, 32'h0000AA00);
    push(32'h22, 1'b1, 3'd1, 32'hBBCC0000);
    push(32'h20, 1'b0, 3'd2, 32'd0);
    run_q(1'b0);

    push(32'h400, 1'b1, 3'd2, $urandom);
    push(32'h21, 1'b1, 3'd1, $urandom);
    push(32'h20, 1'b1, 3'd3, $urandom);
    push(32'h20, 1'b0, 3'd3, 32'd0);
    push(32'h20, 1'b0, 3'd2, 32'd0);
    push(32'h400, 1'b0, 3'd2, 32'd0);
    run_q(1'b0);

    repeat (300) push_random();
    run_q(1'b1);

    sel = 1'b1;
    for (int i = 0; i < 256; i++) push(32'(i * 4), 1'b1, 3'd2, $urandom);
    run_q(1'b1);
    push(32'h10, 1'b1, 3'd2, 32'h0BADF00D);
    push(32'h10, 1'b0, 3'd2, 32'd0);
    push(32'h21, 1'b1, 3'd1, 32'd0);
    push(32'h14, 1'b0, 3'd0, 32'd0);
    run_q(1'b0);
    repeat (150) push_random();
    run_q(1'b1);

    // Abort a waited write with reset; the target word must keep its earlier contents.
    @(negedge clk);
    t_hsel   = 1'b1;
    t_htrans = 2'd2;
    t_haddr  = 32'h30;
    t_hwrite = 1'b1;
    t_hsize  = 3'd2;
    @(negedge clk);
    t_hsel   = 1'b0;
    t_htrans = 2'd0;
    t_hwdata = 32'hCAFEF00D;
    chk("rstmid_wait1", 64'(w_rdy), 64'd0);
    @(negedge clk);
    chk("rstmid_wait2", 64'(w_rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_hreadyout", 64'(w_rdy), 64'd1);
    chk("rstmid_hresp", 64'(w_resp), 64'd0);
    chk("rstmid_hrdata", 64'(w_rdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h30, 1'b0, 3'd2, 32'd0);
    run_q(1'b0);

    sel = 1'b0;
    push(32'h10, 1'b0, 3'd2, 32'd0);
    push(32'h20, 1'b0, 3'd2, 32'd0);
    run_q(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite slave: word-organised on-chip memory with byte-lane writes, programmable wait states and a two-cycle ERROR response. Successor to the fixed single-word ahb_slave, and a drop-in target beside ahb_master. Adds HTRANS/HSIZE decoding, a pipelined address/data phase, configurable depth and width, and protocol-correct error signalling. Sits behind the bus decoder, one instance per HSEL.

## Interface
- ADDR_W, 32, HADDR width
- DATA_W, 32, HWDATA/HRDATA width; 32 or 64
- DEPTH, 256, number of DATA_W words; power of two
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; 0..15

Ports:
- HCLK  in  1  clock; all state on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1=write
- HSIZE  in  3  log2 bytes per transfer
- HWDATA  in  DATA_W  write data, valid in data phase
- HREADY  in  1  bus-level ready (from interconnect)
- HRDATA  out  DATA_W  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Latch addr, write, size, error flag. Otherwise no transfer. IDLE/BUSY get a zero-wait OKAY.
- Word index = HADDR[log2(DEPTH*DATA_W/8)-1 : log2(DATA_W/8)]. Byte lane = low log2(DATA_W/8) address bits.
- ERROR when any of:
  - HADDR ≥ DEPTH*DATA_W/8;
  - HSIZE > log2(DATA_W/8);
  - HADDR not aligned to 2^HSIZE.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted OK transfer → WAIT if WAIT_STATES>0, else DATA. Accepted error → ERR1.
  - WAIT: HREADYOUT=0. Counter loads WAIT_STATES-1 and decrements. At 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle. Write commits the enabled byte lanes at the closing edge. New accepted transfer chains as from IDLE; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Chains like DATA.
- A write never alters memory on error. A read on error returns HRDATA=0.
- Wait states apply only to OKAY transfers. Errors always take exactly 2 cycles.
- Write enable covers bytes lane..lane+2^HSIZE-1, little-endian, taken from the matching HWDATA byte positions.
- HRDATA is combinational from the array at the latched word index. It is valid whenever the state is DATA and the transfer is a read; otherwise it is 0.
- Memory is not reset. Contents are X until written.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0, address/control latches=0.
- Asserting HRESETn mid-transfer aborts it. No memory write occurs and outputs return to reset values immediately (asynchronous).
- Zero-wait latency: data phase is the cycle after the address phase, with HREADYOUT=1 in that cycle.
- With WAIT_STATES=N: the data phase lasts N+1 cycles.
- Pipelining: the next address phase is sampled on the final data-phase cycle (HREADY=1). A write followed by a read of the same word returns the new data, because the commit edge precedes the read data phase.
- Address/control are ignored while HREADY=0. Slave-initiated stalls hold all latched state.
- HWDATA is sampled only on the final data-phase cycle.

## Test plan
- Reset then idle: with HRESETn low, HREADYOUT=1, HRESP=0, HRDATA=0. HTRANS=IDLE with HSEL=1 gives HREADYOUT=1, HRESP=0 every cycle.
- Back-to-back word accesses, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 pipelined.
  - Read data phase returns 0xDEADBEEF.
  - No HREADYOUT-low cycles.
- Byte/halfword lanes:
  - Write word 0x11223344 to 0x20.
  - Write byte 0xAA (HSIZE=0) to 0x21.
  - Write halfword 0xBBCC to 0x22.
  - Read 0x20 → 0xBBCCAA44.
- Wait states, WAIT_STATES=3: read data phase shows HREADYOUT low for exactly 3 cycles, then high with correct HRDATA.
- Errors:
  - Address 0x400 with DEPTH=256, DATA_W=32; misaligned halfword at 0x21; HSIZE=3 on a 32-bit bus.
  - Each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1.
  - A subsequent read shows target memory unchanged.
- Reset mid-wait: assert HRESETn low during a write WAIT cycle. Outputs go to reset values at once, and a later read of that address returns the prior contents.
